// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues reads to a synchronous instruction memory,
// captures {pc, instr} pairs into a circular buffer and hands them to decode
// over valid/ready. Stalls the PC when every slot is reserved and flushes on
// a redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  pc_i,
    output logic                         pc_stall,
    output logic                         im_en,
    output logic [31:0]                  im_addr,
    input  logic [31:0]                  im_rdata,
    input  logic                         redirect,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_pc,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Elaboration-time sanity on the parameters.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("instr_fetch_queue: DEPTH must be a power of two >= 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("instr_fetch_queue: RESET_PC must be word aligned");
    end

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            inflight_v;
    logic [31:0]     inflight_pc;

    logic            pop;
    logic            capture;
    logic            issue_ok;
    logic [SW-1:0]   occupancy;

    // Slot accounting: buffered + in-flight - leaving this cycle must leave room.
    always_comb begin
        pop       = out_valid & out_ready;
        capture   = inflight_v & ~redirect;
        occupancy = SW'(count_q) + SW'(inflight_v) - SW'(pop);
        issue_ok  = occupancy < SW'(DEPTH);
    end

    // Memory strobe and PC hold; redirect and reset never stall the PC.
    always_comb begin
        im_en    = 1'b0;
        pc_stall = 1'b0;
        im_addr  = pc_i;
        if (!rst && !redirect) begin
            im_en    = issue_ok;
            pc_stall = ~issue_ok;
        end
    end

    // Head entry presented to decode; zeroed when empty.
    always_comb begin
        out_valid = (count_q != '0);
        out_instr = '0;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = mem[rd_ptr].instr;
            out_pc    = mem[rd_ptr].pc;
        end
        count = count_q;
    end

    // Queue pointers, occupancy and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q    <= count_q + CW'(capture) - CW'(pop);
            inflight_v <= issue_ok;
            if (issue_ok) begin
                inflight_pc <= pc_i;
            end
        end
    end

    // Entry storage; returned word is paired with the address that fetched it.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            mem[wr_ptr] <= '{pc: inflight_pc, instr: im_rdata};
        end
    end

    // A capture into a full queue means the slot reservation is broken.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(capture && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: PC stage and instruction memory are modelled
// here, with a queue-based reference model of the expected fetch stream.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_i;
    logic          pc_stall;
    logic          im_en;
    logic [31:0]   im_addr;
    logic [31:0]   im_rdata;
    logic          redirect;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;

    logic [31:0]   target;
    logic [31:0]   data_xor;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_i      (pc_i),
        .pc_stall  (pc_stall),
        .im_en     (im_en),
        .im_addr   (im_addr),
        .im_rdata  (im_rdata),
        .redirect  (redirect),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    // PC stage: reset vector, branch target, or +4 unless stalled.
    always @(posedge clk) begin
        if (rst)           pc_i <= RESET_PC;
        else if (redirect) pc_i <= target;
        else if (!pc_stall) pc_i <= pc_i + 32'd4;
    end

    // Synchronous instruction memory: word is a function of its address.
    always @(posedge clk) begin
        if (im_en) im_rdata <= im_addr ^ data_xor;
    end

    // Reference model: queue of fetched PCs plus one outstanding read.
    logic [31:0] m_q[$];
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;

    always @(posedge clk) begin
        int pop_m;
        int ok_m;
        if (rst) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = RESET_PC;
        end else if (redirect) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = target;
        end else begin
            pop_m = (m_q.size() > 0 && out_ready) ? 1 : 0;
            ok_m  = ((m_q.size() + int'(m_infl) - pop_m) < DEPTH) ? 1 : 0;
            if (pop_m != 0) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = (ok_m != 0);
            if (ok_m != 0) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; out_ready = 1'b0; data_xor = '0;
        @(negedge clk);
        checks++; if (im_en !== 1'b0) begin failures++; $display("FAIL rst_im_en: got %b expected 0", im_en); end
        checks++; if (pc_stall !== 1'b0) begin failures++; $display("FAIL rst_pc_stall: got %b expected 0", pc_stall); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (count !== '0) begin failures++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_instr: got %h expected 0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_out_pc: got %h expected 0", out_pc); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (im_en !== 1'b1 || pc_i !== RESET_PC) begin failures++; $display("FAIL first_issue: got im_en=%b pc=%h expected 1 %h", im_en, pc_i, RESET_PC); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1; redirect = 1'b0; data_xor = '0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (im_en !== 1'b1 || pc_stall !== 1'b0 || pc_i !== RESET_PC + 32'(4 * i)) begin failures++; $display("FAIL stream_issue[%0d]: got en=%b stall=%b pc=%h expected 1 0 %h", i, im_en, pc_stall, pc_i, RESET_PC + 32'(4 * i)); end
            checks++; if (count > CW'(1)) begin failures++; $display("FAIL stream_count[%0d]: got %0d expected <=1", i, count); end
            if (i >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(4 * (i - 2)) || out_instr !== RESET_PC + 32'(4 * (i - 2))) begin failures++; $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h expected 1 %h", i, out_valid, out_pc, out_instr, RESET_PC + 32'(4 * (i - 2))); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid[%0d]: got %b expected 0", i, out_valid); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0; redirect = 1'b0; data_xor = '0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 4) begin
                checks++; if (im_en !== 1'b1 || pc_i !== RESET_PC + 32'(4 * i)) begin failures++; $display("FAIL fill_issue[%0d]: got en=%b pc=%h expected 1 %h", i, im_en, pc_i, RESET_PC + 32'(4 * i)); end
            end else begin
                checks++; if (im_en !== 1'b0 || pc_stall !== 1'b1 || pc_i !== 32'h3010) begin failures++; $display("FAIL fill_stall[%0d]: got en=%b stall=%b pc=%h expected 0 1 00003010", i, im_en, pc_stall, pc_i); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); end
    endtask

    task automatic test_full_pop();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin failures++; $display("FAIL fullpop_head: got v=%b pc=%h expected 1 00003000", out_valid, out_pc); end
        checks++; if (im_en !== 1'b1 || pc_stall !== 1'b0 || pc_i !== 32'h3010) begin failures++; $display("FAIL fullpop_issue: got en=%b stall=%b pc=%h expected 1 0 00003010", im_en, pc_stall, pc_i); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (count !== CW'(3) || pc_stall !== 1'b1) begin failures++; $display("FAIL fullpop_mid: got count=%0d stall=%b expected 3 1", count, pc_stall); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (count !== CW'(DEPTH) || out_pc !== 32'h3004) begin failures++; $display("FAIL fullpop_after: got count=%0d pc=%h expected 4 00003004", count, out_pc); end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0; redirect = 1'b0; data_xor = '0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        redirect = 1'b1; target = 32'h0000_3040;
        @(negedge clk);
        checks++; if (count !== CW'(2) || im_en !== 1'b0 || pc_stall !== 1'b0) begin failures++; $display("FAIL redir_cycle: got count=%0d en=%b stall=%b expected 2 0 0", count, im_en, pc_stall); end
        @(posedge clk); #1;
        redirect = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (count !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got count=%0d v=%b expected 0 0", count, out_valid); end
        checks++; if (im_en !== 1'b1 || pc_i !== 32'h3040) begin failures++; $display("FAIL redir_target_issue: got en=%b pc=%h expected 1 00003040", im_en, pc_i); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_stale: got v=%b pc=%h expected valid 0", out_valid, out_pc); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3040 + 32'(4 * i) || out_instr !== 32'h3040 + 32'(4 * i)) begin failures++; $display("FAIL redir_out[%0d]: got v=%b pc=%h instr=%h expected 1 %h", i, out_valid, out_pc, out_instr, 32'h3040 + 32'(4 * i)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; redirect = 1'b0; data_xor = '0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (count !== CW'(3)) begin failures++; $display("FAIL midrst_pre: got count=%0d expected 3", count); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || count !== '0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin failures++; $display("FAIL midrst_clear: got v=%b count=%0d instr=%h pc=%h expected 0 0 0 0", out_valid, count, out_instr, out_pc); end
        checks++; if (im_en !== 1'b1 || pc_i !== RESET_PC) begin failures++; $display("FAIL midrst_restart: got en=%b pc=%h expected 1 %h", im_en, pc_i, RESET_PC); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin failures++; $display("FAIL midrst_first_out: got v=%b pc=%h expected 1 %h", out_valid, out_pc, RESET_PC); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_stress();
        int          pop_e;
        int          ok_e;
        logic [31:0] exp_pc;
        out_ready = 1'b0; redirect = 1'b0; data_xor = $urandom;
        do_reset();
        for (int cyc = 0; cyc < 10000 && failures < 50; cyc++) begin
            out_ready = ($urandom_range(0, 99) < 60);
            redirect  = ($urandom_range(0, 99) == 0);
            if (redirect) target = 32'h0001_0000 + 32'($urandom_range(0, 1023) << 2);
            @(negedge clk);
            pop_e  = (m_q.size() > 0 && out_ready) ? 1 : 0;
            ok_e   = ((m_q.size() + int'(m_infl) - pop_e) < DEPTH) ? 1 : 0;
            exp_pc = (m_q.size() > 0) ? m_q[0] : 32'h0;
            checks++; if (out_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL stress_valid@%0d: got %b expected %b", cyc, out_valid, (m_q.size() > 0)); end
            checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL stress_pc@%0d: got %h expected %h", cyc, out_pc, exp_pc); end
            checks++; if (out_instr !== ((m_q.size() > 0) ? (exp_pc ^ data_xor) : 32'h0)) begin failures++; $display("FAIL stress_instr@%0d: got %h expected %h", cyc, out_instr, (m_q.size() > 0) ? (exp_pc ^ data_xor) : 32'h0); end
            checks++; if (count !== CW'(m_q.size()) || count > CW'(DEPTH)) begin failures++; $display("FAIL stress_count@%0d: got %0d expected %0d", cyc, count, m_q.size()); end
            checks++; if (pc_i !== m_pc) begin failures++; $display("FAIL stress_pc_i@%0d: got %h expected %h", cyc, pc_i, m_pc); end
            if (redirect) begin
                checks++; if (im_en !== 1'b0 || pc_stall !== 1'b0) begin failures++; $display("FAIL stress_redir@%0d: got en=%b stall=%b expected 0 0", cyc, im_en, pc_stall); end
            end else begin
                checks++; if (im_en !== (ok_e != 0) || pc_stall !== (ok_e == 0)) begin failures++; $display("FAIL stress_issue@%0d: got en=%b stall=%b expected %b %b", cyc, im_en, pc_stall, (ok_e != 0), (ok_e == 0)); end
            end
            @(posedge clk); #1;
        end
        redirect = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; out_ready = 1'b0;
        target = '0; data_xor = '0;
        test_reset();
        test_stream();
        test_fill();
        test_full_pop();
        test_redirect();
        test_mid_reset();
        test_random_stress();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
